// File: rtl/bcd_acc_sequencer.sv
// Digit-serial 2-digit BCD accumulator: one shared 4-bit ripple adder sequenced over both digits.
// Optional 7-segment outputs (hex1/hex0) are built when BCD_ACC_HEX_OUT_EN is defined.
module bcd_acc_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter bit WRAP_ON_OVF = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] din,
    input  logic       enter_n,
    input  logic       clr,
    output logic [7:0] acc,
    output logic       busy,
    output logic       done,
    output logic       ovf,
    output logic       err
`ifdef BCD_ACC_HEX_OUT_EN
    ,
    output logic [6:0] hex1,
    output logic [6:0] hex0
`endif
);

    typedef enum logic [2:0] {IDLE, ADD_LO, FIX_LO, ADD_HI, FIX_HI, DONE} state_t;

    state_t                 state_reg;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   hist_reg;
    logic                   ent_reg;
    logic [4:0]             tmp_reg;
    logic                   carry_reg;
    logic [3:0]             operand_reg;

    logic [3:0] add_a;
    logic [3:0] add_b;
    logic       add_cin;
    logic [3:0] add_sum;
    logic       add_cout;
    logic [4:0] add_c;

    // Key synchroniser; ent is a registered one-cycle pulse on the synced falling edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_reg <= '1;
            hist_reg <= 1'b1;
            ent_reg  <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], enter_n};
            hist_reg <= sync_reg[SYNC_STAGES-1];
            ent_reg  <= hist_reg & ~sync_reg[SYNC_STAGES-1];
        end
    end

    // Shared adder operands are selected by the current step.
    always_comb begin
        add_a   = 4'd0;
        add_b   = 4'd0;
        add_cin = 1'b0;
        case (state_reg)
            ADD_LO: begin
                add_a = acc[3:0];
                add_b = operand_reg;
            end
            FIX_LO, FIX_HI: begin
                add_a = tmp_reg[3:0];
                add_b = 4'd6;
            end
            ADD_HI: begin
                add_a   = acc[7:4];
                add_cin = carry_reg;
            end
            default: ;
        endcase
    end

    assign add_c[0] = add_cin;
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ripple
            assign add_sum[gi]  = add_a[gi] ^ add_b[gi] ^ add_c[gi];
            assign add_c[gi+1]  = (add_a[gi] & add_b[gi]) | (add_a[gi] & add_c[gi]) |
                                  (add_b[gi] & add_c[gi]);
        end
    endgenerate
    assign add_cout = add_c[4];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            acc         <= 8'h00;
            busy        <= 1'b0;
            done        <= 1'b0;
            ovf         <= 1'b0;
            err         <= 1'b0;
            tmp_reg     <= 5'd0;
            carry_reg   <= 1'b0;
            operand_reg <= 4'd0;
        end else if (clr) begin
            state_reg <= IDLE;
            acc       <= 8'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
            ovf       <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (ent_reg) begin
                        if (din > 4'd9) begin
                            err <= 1'b1;
                        end else begin
                            err         <= 1'b0;
                            operand_reg <= din;
                            busy        <= 1'b1;
                            state_reg   <= ADD_LO;
                        end
                    end
                end
                ADD_LO: begin
                    tmp_reg   <= {add_cout, add_sum};
                    state_reg <= FIX_LO;
                end
                FIX_LO: begin
                    if (tmp_reg > 5'd9) begin
                        acc[3:0]  <= add_sum;
                        carry_reg <= 1'b1;
                    end else begin
                        acc[3:0]  <= tmp_reg[3:0];
                        carry_reg <= 1'b0;
                    end
                    state_reg <= ADD_HI;
                end
                ADD_HI: begin
                    tmp_reg   <= {add_cout, add_sum};
                    state_reg <= FIX_HI;
                end
                FIX_HI: begin
                    if (tmp_reg <= 5'd9) begin
                        acc[7:4] <= tmp_reg[3:0];
                    end else if (WRAP_ON_OVF) begin
                        acc[7:4] <= add_sum;
                        ovf      <= 1'b1;
                    end else begin
                        acc <= 8'h99;
                        ovf <= 1'b1;
                    end
                    done      <= 1'b1;
                    state_reg <= DONE;
                end
                DONE: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef BCD_ACC_HEX_OUT_EN
    // Segment order {g,f,e,d,c,b,a}, active-low; non-BCD codes blank the digit.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hex1 <= 7'b1000000;
            hex0 <= 7'b1000000;
        end else begin
            hex1 <= seg7(acc[7:4]);
            hex0 <= seg7(acc[3:0]);
        end
    end
`endif

endmodule

// File: doc/bcd_acc_sequencer.md
Name: bcd_acc_sequencer

Overview:
- Digit-serial 2-digit BCD accumulator controller for the board-level adder/display datapath.
- Operator sets a BCD digit on the switches and presses the enter key; the block adds the digit into a 00..99 accumulator.
- A single shared 4-bit ripple adder is sequenced across low digit, +6 correction, high digit and +6 correction.
- Outputs a packed BCD accumulator, status flags and, optionally, active-low 7-segment digit drives.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on enter_n (legal range 2..4).
- WRAP_ON_OVF, 1. 1 = accumulator wraps mod 100 on overflow; 0 = accumulator saturates at 99.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- din  in  4  operand digit (BCD expected).
- enter_n  in  1  raw enter key, active-low, asynchronous to clk.
- clr  in  1  synchronous clear, active-high.
- acc  out  8  accumulator, {tens, units} BCD.
- busy  out  1  high while an add is in flight.
- done  out  1  one-cycle pulse when acc is updated.
- ovf  out  1  sticky overflow (sum exceeded 99).
- err  out  1  last enter carried din > 9.
- hex1, hex0  out  7 each  present only with HEX_OUT_EN.

Behaviour:
- Reset:
  - Applied when rst_n = 0 at a clk edge.
  - acc = 0x00; busy, done, ovf, err = 0; state = IDLE.
  - All sync flops = 1 (key released); tmp, carry and operand = 0.
- Enter detect:
  - enter_n passes through SYNC_STAGES flops plus one history flop.
  - A 1->0 transition of the synced signal produces a one-cycle internal pulse ent.
  - Latency from the enter_n fall to ent is SYNC_STAGES+1 cycles.
- Single adder instance, inputs a, b, cin, outputs sum[3:0] and cout. Operands are muxed by state; no second adder is allowed.
- FSM states: IDLE, ADD_LO, FIX_LO, ADD_HI, FIX_HI, DONE.
  - IDLE:
    - ent with din > 9: err <= 1; acc unchanged; stay in IDLE.
    - ent with din <= 9: err <= 0; operand <= din; busy <= 1; go to ADD_LO.
  - ADD_LO:
    - a = acc[3:0], b = operand, cin = 0.
    - tmp <= {cout, sum} (5 bits); go to FIX_LO.
  - FIX_LO:
    - If tmp > 9: a = tmp[3:0], b = 6, cin = 0; acc[3:0] <= sum; carry <= 1.
    - Else: acc[3:0] <= tmp[3:0]; carry <= 0.
    - Go to ADD_HI.
  - ADD_HI:
    - a = acc[7:4], b = 0, cin = carry.
    - tmp <= {cout, sum}; go to FIX_HI.
  - FIX_HI:
    - If tmp <= 9: acc[7:4] <= tmp[3:0].
    - If tmp > 9 and WRAP_ON_OVF = 1: acc[7:4] <= tmp[3:0] + 6 (via adder); ovf <= 1.
    - If tmp > 9 and WRAP_ON_OVF = 0: acc <= 0x99; ovf <= 1.
    - Go to DONE.
  - DONE: done = 1 for this cycle; busy <= 0; go to IDLE.
- Timing:
  - Accept (ent in IDLE) to done is 5 cycles; acc is final in the done cycle.
  - busy is high from the cycle after accept through the done cycle.
- ent outside IDLE is dropped: no queueing, err unaffected.
- clr:
  - Priority below rst_n, above everything else.
  - acc = 0, ovf = 0, err = 0, busy = 0, done = 0, state = IDLE, effective next edge.
  - An add in flight is aborted with no done pulse.
  - An ent in the same cycle as clr is dropped.
- ovf: cleared only by rst_n or clr.
- err: cleared by an accepted valid enter, rst_n or clr.

Optional Feature:
- Macro: BCD_ACC_HEX_OUT_EN.
- Defined:
  - Ports hex1 and hex0 exist, bit order {g,f,e,d,c,b,a}, active-low (common anode).
  - hex1 decodes acc[7:4]; hex0 decodes acc[3:0].
  - Outputs are registered, updating one cycle after acc changes.
  - Reset value is 7'b1000000 (digit 0) on both.
- Undefined: hex ports and decoder logic are absent; all other behaviour is identical.

Test Plan:
- Reset, din = 7, pulse enter_n -> ent after 3 cycles; done 5 cycles after accept; acc = 0x07, ovf = 0, err = 0.
- From acc = 0x07, din = 5 enter -> acc = 0x12 (low-digit +6 correction and carry exercised).
- acc = 0x95, din = 9 enter -> WRAP_ON_OVF = 1: acc = 0x04, ovf = 1. WRAP_ON_OVF = 0: acc = 0x99, ovf = 1.
- din = 0xB enter -> err = 1, busy stays 0, acc unchanged. Then din = 3 enter -> err = 0, acc increases by 3 BCD.
- Second enter during busy -> ignored, exactly one done. clr asserted in ADD_HI -> next cycle acc = 0x00, busy = 0, no done.
- With BCD_ACC_HEX_OUT_EN, acc = 0x42 -> hex1 = 7'b0011001, hex0 = 7'b0100100 one cycle later. After reset, both = 7'b1000000.
